ysyx_25020047_lsu: RTL

YSYX_25020047_LSU -- requirements
Module: ysyx_25020047_LSU

---
 rtl/ysyx_25020047_pkg.sv | 41 ++++
 rtl/ysyx_25020047_LSU_align.sv | 33 +++
 rtl/ysyx_25020047_lsu.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ysyx_25020047_pkg.sv
// Shared LSU definitions: one-hot inst_type opcodes, FSM states and decoded memory op.
package ysyx_25020047_pkg;

    localparam logic [31:0] INST_LW  = 32'h0000_0020;
    localparam logic [31:0] INST_LBU = 32'h0000_0040;
    localparam logic [31:0] INST_SW  = 32'h0000_0080;
    localparam logic [31:0] INST_SB  = 32'h0000_0100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } lsu_state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_LW,
        OP_LBU,
        OP_SW,
        OP_SB
    } mem_op_e;

    // Anything that is not exactly one of the memory opcodes passes through as a non-memory op.
    function automatic mem_op_e decode_op(input logic [31:0] inst_type);
        mem_op_e op;
        case (inst_type)
            INST_LW:  op = OP_LW;
            INST_LBU: op = OP_LBU;
            INST_SW:  op = OP_SW;
            INST_SB:  op = OP_SB;
            default:  op = OP_NONE;
        endcase
        return op;
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/ysyx_25020047_LSU_align.sv
// Combinational byte-lane logic: load extraction/zero-extension and store mask/data replication.
module ysyx_25020047_LSU_align
    import ysyx_25020047_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    always_comb begin
        wmask     = '0;
        wdata     = '0;
        load_data = '0;
        case (op)
            OP_LW:  load_data = rdata;
            OP_LBU: load_data = {24'b0, rdata[{byte_sel, 3'b000} +: 8]};
            OP_SW: begin
                wmask = 4'b1111;
                wdata = st_data;
            end
            OP_SB: begin
                wmask = 4'b0001 << byte_sel;
                wdata = {4{st_data[7:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one outstanding access over a req/gnt/rvalid memory port with
// misalignment and timeout aborts, result handed to writeback via valid/ready.
module ysyx_25020047_lsu
    import ysyx_25020047_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst_type,
    input  logic [31:0]       addr,
    input  logic [31:0]       st_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [31:0]       memdata,
    input  logic              out_ready,
    output logic              misalign,
    output logic              timeout
);

    lsu_state_e        state, state_next;
    mem_op_e           op_in, op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       st_data_q;
    logic [7:0]        cnt;
    logic [31:0]       memdata_q;
    logic              misalign_q, timeout_q;
    logic              accept, in_misalign, resp, expired;
    logic [3:0]        wmask;
    logic [31:0]       wdata, load_data;

    assign op_in       = decode_op(inst_type);
    assign accept      = in_valid && (state == S_IDLE);
    assign in_misalign = ((op_in == OP_LW) || (op_in == OP_SW)) && (addr[1:0] != 2'b00);
    // Responses only count while granted in REQ or waiting in WAIT; stray acks elsewhere are dropped.
    assign resp        = mem_rvalid && (((state == S_REQ) && mem_gnt) || (state == S_WAIT));
    assign expired     = (32'(cnt) + 32'd1) >= TIMEOUT_CYC;

    ysyx_25020047_LSU_align u_align (
        .op        (op_q),
        .byte_sel  (addr_q[1:0]),
        .st_data   (st_data_q),
        .rdata     (mem_rdata),
        .wmask     (wmask),
        .wdata     (wdata),
        .load_data (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = ((op_in == OP_NONE) || in_misalign) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                if (resp || expired) state_next = S_DONE;
                else if (mem_gnt)    state_next = S_WAIT;
            end
            S_WAIT: begin
                if (resp || expired) state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_NONE;
            addr_q     <= '0;
            st_data_q  <= '0;
            cnt        <= '0;
            memdata_q  <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q       <= op_in;
                        addr_q     <= addr[ADDR_W-1:0];
                        st_data_q  <= st_data;
                        cnt        <= '0;
                        memdata_q  <= '0;
                        misalign_q <= in_misalign;
                        timeout_q  <= 1'b0;
                    end
                end
                S_REQ, S_WAIT: begin
                    if (cnt != 8'hFF) cnt <= cnt + 8'd1;
                    // A response in the final allowed cycle still wins over the timeout.
                    if (resp) begin
                        memdata_q <= load_data;
                    end else if (expired) begin
                        memdata_q <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign mem_req   = (state == S_REQ);
    assign mem_we    = mem_req && is_store(op_q);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wmask = mem_req ? wmask : '0;
    assign mem_wdata = mem_req ? wdata : '0;
    assign out_valid = (state == S_DONE);
    assign memdata   = memdata_q;
    assign misalign  = misalign_q;
    assign timeout   = timeout_q;

endmodule
